// File: rtl/miner_dma_pkg.sv
// Shared types and constants for the miner host-port to AFU DMA bridge.
package miner_dma_pkg;

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    IDLE     = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    WR_ISSUE = 3'd4,
    WR_WAIT  = 3'd5
  } bridge_state_t;

  // log2 of the cache-line size in bytes; DMA addresses are line aligned
  localparam int CL_BYTE_OFS = 6;

  // Cycles allowed between a DMA go and its done before the bridge gives up
  localparam int DEF_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/dma_timeout_ctr.sv
// Completion watchdog shared by the read and write WAIT states.
// Cleared on each DMA go, counts while enabled, flags expiry on the last cycle.
module dma_timeout_ctr
  import miner_dma_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Wait-cycle counter; holds at the terminal value until the next clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && !expired) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign expired = (r_cnt == LAST);

endmodule

// File: rtl/miner_dma_bridge.sv
// Bridge from the miner host strobes to single-line AFU DMA transactions.
// One read outstanding plus one pending write slot; reads take priority.
module miner_dma_bridge
  import miner_dma_pkg::*;
#(
  parameter int ADDR_W         = 64,
  parameter int CL_W           = 512,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_init,
  input  logic              host_re,
  input  logic              host_rgo,
  input  logic              host_we,
  input  logic              host_wgo,
  input  logic [ADDR_W-1:0] corrected_address,
  input  logic [CL_W-1:0]   host_data_bus_write_out,
  output logic              host_rd_ready,
  output logic              host_wr_ready,
  output logic [CL_W-1:0]   host_data_bus_read_in,
  input  logic              dma_rd_ready,
  output logic              dma_rd_go,
  output logic [ADDR_W-1:0] dma_rd_addr,
  input  logic              dma_rd_done,
  input  logic [CL_W-1:0]   dma_rd_data,
  input  logic              dma_wr_ready,
  output logic              dma_wr_go,
  output logic [ADDR_W-1:0] dma_wr_addr,
  output logic [CL_W-1:0]   dma_wr_data,
  input  logic              dma_wr_done,
  output logic              err_timeout,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((64'd1 << CL_BYTE_OFS) - 64'd1);

  bridge_state_t     r_state;
  bridge_state_t     w_state_nxt;
  logic              r_rd_pend;
  logic              r_slot_full;
  logic              r_rd_ready;
  logic              r_wr_ready;
  logic              r_err;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [CL_W-1:0]   r_wr_data;
  logic [CL_W-1:0]   r_rd_data;
  logic [CNT_W-1:0]  r_rd_cnt;
  logic [CNT_W-1:0]  r_wr_cnt;

  logic w_rd_acc;
  logic w_wr_acc;
  logic w_rd_go;
  logic w_wr_go;
  logic w_expired;
  logic w_wait;
  logic w_rd_fin;
  logic w_rd_to;
  logic w_wr_fin;
  logic w_wr_to;
  logic w_slot_nxt;

  assign w_rd_acc   = host_re & host_rgo & r_rd_ready;
  assign w_wr_acc   = host_we & host_wgo & r_wr_ready;
  assign w_wait     = (r_state == RD_WAIT) || (r_state == WR_WAIT);
  // A done in the same cycle as expiry still counts as a completion
  assign w_rd_fin   = (r_state == RD_WAIT) && dma_rd_done;
  assign w_rd_to    = (r_state == RD_WAIT) && !dma_rd_done && w_expired;
  assign w_wr_fin   = (r_state == WR_WAIT) && dma_wr_done;
  assign w_wr_to    = (r_state == WR_WAIT) && !dma_wr_done && w_expired;
  assign w_slot_nxt = (r_slot_full | w_wr_acc) & ~(w_wr_fin | w_wr_to);

  dma_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_rd_go | w_wr_go),
    .en     (w_wait),
    .expired(w_expired)
  );

  // Next-state and go-pulse decode
  always_comb begin
    w_state_nxt = r_state;
    w_rd_go     = 1'b0;
    w_wr_go     = 1'b0;
    unique case (r_state)
      INIT: begin
        if (host_init) w_state_nxt = IDLE;
      end
      IDLE: begin
        if (w_rd_acc || r_rd_pend) begin
          w_state_nxt = RD_ISSUE;
        end else if (r_slot_full || w_wr_acc) begin
          w_state_nxt = WR_ISSUE;
        end
      end
      RD_ISSUE: begin
        if (dma_rd_ready) begin
          w_rd_go     = 1'b1;
          w_state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (dma_rd_done || w_expired) w_state_nxt = IDLE;
      end
      WR_ISSUE: begin
        if (dma_wr_ready) begin
          w_wr_go     = 1'b1;
          w_state_nxt = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (dma_wr_done || w_expired) w_state_nxt = IDLE;
      end
      default: w_state_nxt = INIT;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= INIT;
    else     r_state <= w_state_nxt;
  end

  // Capture accepted requests; a read accepted outside IDLE waits as pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_pend   <= 1'b0;
      r_rd_addr   <= '0;
      r_slot_full <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_rd_pend   <= (r_rd_pend | w_rd_acc) & (r_state != IDLE);
      r_slot_full <= w_slot_nxt;
      if (w_rd_acc) r_rd_addr <= corrected_address & LINE_MASK;
      if (w_wr_acc) begin
        r_wr_addr <= corrected_address & LINE_MASK;
        r_wr_data <= host_data_bus_write_out;
      end
    end
  end

  // Registered host handshakes; both stay low until INIT has been left
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ready <= 1'b0;
      r_wr_ready <= 1'b0;
    end else begin
      r_rd_ready <= (r_state == IDLE) && !w_rd_acc && !r_rd_pend;
      r_wr_ready <= (r_state != INIT) && !w_slot_nxt;
    end
  end

  // Read return path, completion counters and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= '0;
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_rd_fin) begin
        r_rd_data <= dma_rd_data;
        r_rd_cnt  <= r_rd_cnt + CNT_W'(1);
      end else if (w_rd_to) begin
        r_rd_data <= '1;
      end
      if (w_wr_fin) r_wr_cnt <= r_wr_cnt + CNT_W'(1);
      if (w_rd_to || w_wr_to) r_err <= 1'b1;
    end
  end

  assign host_rd_ready         = r_rd_ready;
  assign host_wr_ready         = r_wr_ready;
  assign host_data_bus_read_in = r_rd_data;
  assign dma_rd_go             = w_rd_go;
  assign dma_rd_addr           = r_rd_addr;
  assign dma_wr_go             = w_wr_go;
  assign dma_wr_addr           = r_wr_addr;
  assign dma_wr_data           = r_wr_data;
  assign err_timeout           = r_err;
  assign rd_count              = r_rd_cnt;
  assign wr_count              = r_wr_cnt;

endmodule

// File: tb/tb_miner_dma_bridge.sv
// Scoreboard bench for miner_dma_bridge: directed scenarios plus a randomized
// phase; a DMA responder model and a decoupled monitor check every transaction.
module tb_miner_dma_bridge;

  localparam int AW = 64;
  localparam int CW = 512;
  localparam int TO = 16;
  localparam int NW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          host_init, host_re, host_rgo, host_we, host_wgo;
  logic [AW-1:0] corrected_address;
  logic [CW-1:0] host_data_bus_write_out;
  logic          host_rd_ready, host_wr_ready;
  logic [CW-1:0] host_data_bus_read_in;
  logic          dma_rd_ready, dma_rd_go, dma_rd_done;
  logic [AW-1:0] dma_rd_addr;
  logic [CW-1:0] dma_rd_data;
  logic          dma_wr_ready, dma_wr_go, dma_wr_done;
  logic [AW-1:0] dma_wr_addr;
  logic [CW-1:0] dma_wr_data;
  logic          err_timeout;
  logic [NW-1:0] rd_count, wr_count;

  always #5 clk = ~clk;

  miner_dma_bridge #(
    .ADDR_W(AW), .CL_W(CW), .TIMEOUT_CYCLES(TO), .CNT_W(NW)
  ) dut (
    .clk(clk), .rst(rst), .host_init(host_init),
    .host_re(host_re), .host_rgo(host_rgo), .host_we(host_we), .host_wgo(host_wgo),
    .corrected_address(corrected_address),
    .host_data_bus_write_out(host_data_bus_write_out),
    .host_rd_ready(host_rd_ready), .host_wr_ready(host_wr_ready),
    .host_data_bus_read_in(host_data_bus_read_in),
    .dma_rd_ready(dma_rd_ready), .dma_rd_go(dma_rd_go), .dma_rd_addr(dma_rd_addr),
    .dma_rd_done(dma_rd_done), .dma_rd_data(dma_rd_data),
    .dma_wr_ready(dma_wr_ready), .dma_wr_go(dma_wr_go), .dma_wr_addr(dma_wr_addr),
    .dma_wr_data(dma_wr_data), .dma_wr_done(dma_wr_done),
    .err_timeout(err_timeout), .rd_count(rd_count), .wr_count(wr_count)
  );

  int checks   = 0;
  int failures = 0;

  // Scoreboard queues and reference state
  logic [AW-1:0]    exp_ra_q[$];
  logic [AW+CW-1:0] exp_w_q[$];
  logic [CW-1:0]    exp_rd_q[$];
  int unsigned      m_rd = 0, m_wr = 0;
  int               rd_mode = 0;      // 0 respond, 1 never respond (timeout), 2 ignore
  int               rd_lat = 2, wr_lat = 2;
  bit               rand_lat = 0, rand_bp = 0, use_fixed = 0;
  logic [CW-1:0]    fixed_data = {64{8'hA5}};
  bit               rd_out = 0;
  int               cyc = 0, rd_go_cyc = 0, wr_go_cyc = 0;
  logic [AW+CW-1:0] wexp;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=none required=event", name);
  endtask

  function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
    return a - (a % 64);
  endfunction

  function automatic logic [CW-1:0] rand_line();
    logic [CW-1:0] v;
    for (int i = 0; i < CW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Monitor: compares every DMA request and every read return against the queues
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      rd_out = 0;
    end else begin
      if (dma_rd_go) begin
        rd_go_cyc = cyc;
        if (exp_ra_q.size() == 0) fail_now("rd_go_unexpected");
        else chk("rd_addr", dma_rd_addr, exp_ra_q.pop_front());
        rd_out = 1;
      end
      if (dma_wr_go) begin
        wr_go_cyc = cyc;
        if (exp_w_q.size() == 0) fail_now("wr_go_unexpected");
        else begin
          wexp = exp_w_q.pop_front();
          chk("wr_addr", dma_wr_addr, wexp[AW+CW-1:CW]);
          chk("wr_data", dma_wr_data, wexp[CW-1:0]);
        end
      end
      if (rd_out && host_rd_ready) begin
        if (exp_rd_q.size() == 0) fail_now("rd_data_unexpected");
        else chk("rd_data", host_data_bus_read_in, exp_rd_q.pop_front());
        chk("rd_count_at_return", rd_count, m_rd);
        rd_out = 0;
      end
    end
  end

  // DMA read engine model
  initial begin
    int            lat;
    logic [CW-1:0] d;
    dma_rd_done = 1'b0;
    dma_rd_data = '0;
    forever begin
      @(negedge clk);
      if (!rst && dma_rd_go) begin
        if (rd_mode == 0) begin
          lat = rand_lat ? int'($urandom_range(1, 6)) : rd_lat;
          d   = use_fixed ? fixed_data : rand_line();
          repeat (lat) @(negedge clk);
          dma_rd_data = d;
          dma_rd_done = 1'b1;
          exp_rd_q.push_back(d);
          m_rd++;
          @(negedge clk);
          dma_rd_done = 1'b0;
        end else if (rd_mode == 1) begin
          exp_rd_q.push_back('1);
        end
      end
    end
  end

  // DMA write engine model
  initial begin
    int lat;
    dma_wr_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && dma_wr_go) begin
        lat = rand_lat ? int'($urandom_range(1, 6)) : wr_lat;
        repeat (lat) @(negedge clk);
        dma_wr_done = 1'b1;
        m_wr++;
        @(negedge clk);
        dma_wr_done = 1'b0;
      end
    end
  end

  // Random DMA backpressure, changed just after the active edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_bp) begin
        dma_rd_ready = ($urandom_range(0, 3) != 0);
        dma_wr_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic set_dma_ready(input logic r, input logic w);
    @(posedge clk);
    #1;
    dma_rd_ready = r;
    dma_wr_ready = w;
    @(negedge clk);
  endtask

  task automatic wait_ready(input bit rd, input bit wr);
    int n = 0;
    while (!((!rd || host_rd_ready) && (!wr || host_wr_ready)) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail_now("wait_host_ready");
  endtask

  // Host side: one launch cycle; junk raises strobes without their qualifiers
  task automatic issue(input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [CW-1:0] wd, input bit junk);
    wait_ready(rd, wr);
    corrected_address       = a;
    host_data_bus_write_out = wd;
    host_re  = rd;
    host_rgo = rd | junk;
    host_we  = wr;
    host_wgo = wr | junk;
    if (rd) exp_ra_q.push_back(line_of(a));
    if (wr) exp_w_q.push_back({line_of(a), wd});
    @(negedge clk);
    host_re = 0; host_rgo = 0; host_we = 0; host_wgo = 0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(host_rd_ready && host_wr_ready && !rd_out && exp_ra_q.size() == 0 &&
             exp_w_q.size() == 0 && exp_rd_q.size() == 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) fail_now({name, "_drain"});
    chk({name, "_rd_count"}, rd_count, m_rd);
    chk({name, "_wr_count"}, wr_count, m_wr);
  endtask

  task automatic wait_rd_go();
    int n = 0;
    while (!dma_rd_go && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now("wait_rd_go");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   bad;
    int   gos;
    int   n;
    int   k;
    logic [AW-1:0] a;
    rst = 1; host_init = 0; host_re = 0; host_rgo = 0; host_we = 0; host_wgo = 0;
    corrected_address = '0; host_data_bus_write_out = '0;
    dma_rd_ready = 1; dma_wr_ready = 1;
    repeat (2) @(negedge clk);
    chk("rst_ctrl_outs", {host_rd_ready, host_wr_ready, dma_rd_go, dma_wr_go, err_timeout}, '0);
    chk("rst_rd_data", host_data_bus_read_in, '0);
    chk("rst_addrs", {dma_rd_addr, dma_wr_addr}, '0);
    chk("rst_wr_data", dma_wr_data, '0);
    chk("rst_counts", {rd_count, wr_count}, '0);
    rst = 0;

    // Bridge must stay idle until host_init is seen
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      host_re = 1; host_rgo = 1;
      @(negedge clk);
      bad |= dma_rd_go | host_rd_ready | host_wr_ready;
    end
    host_re = 0; host_rgo = 0;
    chk("init_gating", bad, 0);
    host_init = 1;
    @(negedge clk);
    chk("init_ready_1cyc", host_rd_ready, 0);
    @(negedge clk);
    chk("init_ready_2cyc", {host_rd_ready, host_wr_ready}, 2'b11);

    // Basic read, done five cycles after go
    use_fixed = 1; rd_lat = 5;
    issue(1, 0, 64'h1000_0047, '0, 0);
    n = 0;
    while (!dma_rd_done && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) fail_now("basic_done_seen");
    chk("basic_data_before_done", host_data_bus_read_in, '0);
    @(negedge clk);
    chk("basic_data_after_done", host_data_bus_read_in, {64{8'hA5}});
    wait_idle("basic");
    chk("basic_rd_count", rd_count, 1);
    use_fixed = 0; rd_lat = 2;

    // Read and write launched in the same cycle: read goes first
    rd_go_cyc = 0; wr_go_cyc = 0;
    issue(1, 1, 64'h2000, 512'h1234, 0);
    wait_idle("simul");
    chk("simul_order", (rd_go_cyc > 0) && (rd_go_cyc < wr_go_cyc), 1);
    chk("simul_counts", {rd_count, wr_count}, {32'd2, 32'd1});

    // Write backpressure
    set_dma_ready(1, 0);
    issue(0, 1, 64'h4000_00BF, rand_line(), 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      bad |= dma_wr_go | host_wr_ready;
      @(negedge clk);
    end
    chk("bp_withheld", bad, 0);
    set_dma_ready(1, 1);
    gos = 0;
    for (int i = 0; i < 10; i++) begin
      gos += int'(dma_wr_go);
      @(negedge clk);
    end
    chk("bp_single_go", gos, 1);
    wait_idle("bp");

    // Read timeout, then a late done that must be ignored
    rd_mode = 1;
    issue(1, 0, 64'h0000_0000_6000_0001, '0, 0);
    wait_rd_go();
    repeat (TO) @(negedge clk);
    chk("to_err_not_yet", err_timeout, 0);
    @(negedge clk);
    chk("to_err_set", err_timeout, 1);
    chk("to_rd_count", rd_count, m_rd);
    chk("to_rd_data_ones", host_data_bus_read_in, '1);
    dma_rd_data = rand_line();
    dma_rd_done = 1;
    @(negedge clk);
    dma_rd_done = 0;
    repeat (2) @(negedge clk);
    chk("late_done_count", rd_count, m_rd);
    chk("late_done_data", host_data_bus_read_in, '1);
    rd_mode = 0;
    wait_idle("timeout");
    chk("to_err_sticky", err_timeout, 1);

    // Randomized traffic with backpressure and variable latency
    rand_bp = 1; rand_lat = 1;
    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 2));
      a = {$urandom, $urandom};
      issue(k != 1, k != 0, a, rand_line(), bit'($urandom_range(0, 1)));
    end
    rand_bp = 0; rand_lat = 0;
    set_dma_ready(1, 1);
    wait_idle("random");

    // Reset while a read is waiting for completion
    rd_mode = 2;
    issue(1, 0, 64'h5000_0010, '0, 0);
    wait_rd_go();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    chk("mid_rst_ctrl_outs", {host_rd_ready, host_wr_ready, dma_rd_go, dma_wr_go, err_timeout}, '0);
    chk("mid_rst_rd_data", host_data_bus_read_in, '0);
    chk("mid_rst_counts", {rd_count, wr_count}, '0);
    chk("mid_rst_addr", dma_rd_addr, '0);
    m_rd = 0; m_wr = 0;
    @(posedge clk);
    #2;
    rst = 0;
    @(negedge clk);
    dma_rd_data = rand_line();
    dma_rd_done = 1;
    @(negedge clk);
    dma_rd_done = 0;
    repeat (3) @(negedge clk);
    chk("post_rst_rd_count", rd_count, 0);
    chk("post_rst_rd_data", host_data_bus_read_in, '0);
    chk("post_rst_ready", {host_rd_ready, host_wr_ready}, 2'b11);
    rd_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
